// File: rtl/blockmem_pkg.sv
// Shared types and width helpers for the two-port block memory and its clear sequencer.
package blockmem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Data width rounded up to whole bytes.
  function automatic int pad_width(input int dw);
    return ((dw + 7) / 8) * 8;
  endfunction

  function automatic int byte_count(input int dw);
    return pad_width(dw) / 8;
  endfunction

  function automatic int we_width(input int dw, input int bwen);
    return (bwen != 0) ? byte_count(dw) : 1;
  endfunction

endpackage

// File: rtl/blockmem_2p_clr.sv
// Clear sequencer: sweeps zeros through every address, once after reset release
// (when enabled) and again on each clr request seen while idle.
module blockmem_2p_clr
  import blockmem_pkg::*;
#(
  parameter int G_MEMDEPTH       = 1024,
  parameter int G_ADDRWIDTH      = 10,
  parameter int G_CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  output logic                   busy,
  output logic [G_ADDRWIDTH-1:0] clr_addr,
  output clr_state_t             state
);

  localparam logic [G_ADDRWIDTH-1:0] LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);

  clr_state_t             state_nx;
  logic [G_ADDRWIDTH-1:0] addr_nx;
  logic                   start_pend;

  // start_pend marks the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_addr   <= '0;
      start_pend <= (G_CLEAR_ON_RESET != 0);
    end else begin
      state      <= state_nx;
      clr_addr   <= addr_nx;
      start_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = clr_addr;
    case (state)
      ST_IDLE: begin
        if (start_pend || clr) begin
          state_nx = ST_CLEAR;
          addr_nx  = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          state_nx = ST_IDLE;
          addr_nx  = '0;
        end else begin
          addr_nx = clr_addr + 1'b1;
        end
      end
    endcase
  end

  assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/blockmem_2p_fwd.sv
// Simple dual-port block memory: byte-enabled write port A, read port B with
// 1- or 2-cycle latency, optional write-first forwarding and a hardware clear sweep.
module blockmem_2p_fwd
  import blockmem_pkg::*;
#(
  parameter int    G_DATAWIDTH      = 32,
  parameter int    G_MEMDEPTH       = 1024,
  parameter int    G_BWENABLE       = 0,
  parameter int    G_RDLATENCY      = 1,
  parameter int    G_FORWARD        = 1,
  parameter int    G_CLEAR_ON_RESET = 1,
  parameter string G_INIT_FILE      = "",
  localparam int   G_ADDRWIDTH      = $clog2(G_MEMDEPTH),
  localparam int   G_PADWIDTH       = pad_width(G_DATAWIDTH),
  localparam int   G_WEWIDTH        = we_width(G_DATAWIDTH, G_BWENABLE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [G_WEWIDTH-1:0]   wea,
  input  logic [G_ADDRWIDTH-1:0] addra,
  input  logic [G_DATAWIDTH-1:0] dina,
  input  logic                   clr,
  input  logic                   enb,
  input  logic [G_ADDRWIDTH-1:0] addrb,
  output logic [G_DATAWIDTH-1:0] doutb,
  output logic                   doutb_valid,
  output logic                   busy
);

  localparam int NBYTES = byte_count(G_DATAWIDTH);

  if (G_RDLATENCY != 1 && G_RDLATENCY != 2) begin : g_bad_latency
    $error("blockmem_2p_fwd: G_RDLATENCY must be 1 or 2");
  end
  if (G_MEMDEPTH < 2) begin : g_bad_depth
    $error("blockmem_2p_fwd: G_MEMDEPTH must be at least 2");
  end

  logic [G_PADWIDTH-1:0]  mem [G_MEMDEPTH];
  logic [NBYTES-1:0]      be;
  logic [G_PADWIDTH-1:0]  wdata_pad;
  logic [G_PADWIDTH-1:0]  rd_old;
  logic [G_PADWIDTH-1:0]  rd_word;
  logic                   wr_fire;
  logic                   rd_fire;
  logic                   rd_in_range;
  logic                   clr_we;
  logic [G_ADDRWIDTH-1:0] clr_addr;
  clr_state_t             clr_state;

  blockmem_2p_clr #(
    .G_MEMDEPTH      (G_MEMDEPTH),
    .G_ADDRWIDTH     (G_ADDRWIDTH),
    .G_CLEAR_ON_RESET(G_CLEAR_ON_RESET)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_addr(clr_addr),
    .state   (clr_state)
  );

  function automatic logic [G_PADWIDTH-1:0] merge_bytes(
    input logic [G_PADWIDTH-1:0] old_word,
    input logic [G_PADWIDTH-1:0] new_word,
    input logic [NBYTES-1:0]     byte_en
  );
    logic [G_PADWIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign clr_we    = (clr_state == ST_CLEAR);
  assign wdata_pad = G_PADWIDTH'(dina);
  assign be        = (G_BWENABLE != 0) ? NBYTES'(wea) : {NBYTES{wea[0]}};
  assign wr_fire   = ena && !busy && (int'(addra) < G_MEMDEPTH);
  // A read is accepted whenever enb is high outside a clear; there is no back-pressure.
  assign rd_fire     = enb && !busy;
  assign rd_in_range = (int'(addrb) < G_MEMDEPTH);

  always_comb begin
    rd_old = '0;
    if (rd_in_range) rd_old = mem[addrb];
    rd_word = rd_old;
    if (G_FORWARD != 0 && wr_fire && rd_in_range && (addra == addrb)) begin
      rd_word = merge_bytes(rd_old, wdata_pad, be);
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[addra] <= merge_bytes(mem[addra], wdata_pad, be);
    end
  end

  logic                   rd_valid1;
  logic [G_DATAWIDTH-1:0] rd_data1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid1 <= 1'b0;
      rd_data1  <= '0;
    end else begin
      rd_valid1 <= rd_fire;
      if (rd_fire) rd_data1 <= rd_word[G_DATAWIDTH-1:0];
    end
  end

  if (G_RDLATENCY == 2) begin : g_lat2
    logic                   rd_valid2;
    logic [G_DATAWIDTH-1:0] rd_data2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid2 <= 1'b0;
        rd_data2  <= '0;
      end else begin
        rd_valid2 <= rd_valid1;
        if (rd_valid1) rd_data2 <= rd_data1;
      end
    end

    assign doutb       = rd_data2;
    assign doutb_valid = rd_valid2;
  end else begin : g_lat1
    assign doutb       = rd_data1;
    assign doutb_valid = rd_valid1;
  end

endmodule
